// File: rtl/aes_round_key_sequencer_if.sv
// Round-key stream between the key sequencer (master) and the AES round
// datapath (slave). One key is transferred on each rk_valid && rk_ready.
interface aes_round_key_sequencer_if #(
    parameter int RK_W  = 128,
    parameter int IDX_W = 4
);
    logic             rk_valid;
    logic             rk_ready;
    logic [RK_W-1:0]  rk_data;
    logic [IDX_W-1:0] rk_round;
    logic             rk_last;

    modport master (
        output rk_valid,
        output rk_data,
        output rk_round,
        output rk_last,
        input  rk_ready
    );

    modport slave (
        input  rk_valid,
        input  rk_data,
        input  rk_round,
        input  rk_last,
        output rk_ready
    );
endinterface

// File: rtl/aes_round_key_sequencer.sv
// AES round-key sequencer: latches a cipher key/algorithm, walks the
// combinational key_module through round indices 0..Nr (encrypt) or
// Nr..0 (decrypt) and presents each registered round key on a
// valid/ready stream, one key every two cycles at full rate.
module aes_round_key_sequencer #(
    parameter int KEY_W = 256,
    parameter int RK_W  = 128,
    parameter int IDX_W = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [KEY_W-1:0]              key,
    input  logic [1:0]                    algorithm,
    input  logic                          decrypt,
    output logic [KEY_W-1:0]              km_key,
    output logic [1:0]                    km_algorithm,
    output logic [IDX_W-1:0]              km_i,
    input  logic [RK_W-1:0]               km_rk,
    aes_round_key_sequencer_if.master     rk,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t state;
    logic   dir;    // 1 = schedule runs downwards (decrypt)

    // Final round number Nr for a legal algorithm code; 0 for the illegal code.
    function automatic logic [IDX_W-1:0] last_round(input logic [1:0] alg);
        logic [IDX_W-1:0] nr;
        case (alg)
            2'b00:   nr = IDX_W'(10);
            2'b01:   nr = IDX_W'(12);
            2'b10:   nr = IDX_W'(14);
            default: nr = '0;
        endcase
        return nr;
    endfunction

    // Index at which the schedule ends: 0 going down, Nr going up.
    function automatic logic [IDX_W-1:0] end_index(input logic down, input logic [1:0] alg);
        return down ? {IDX_W{1'b0}} : last_round(alg);
    endfunction

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dir          <= 1'b0;
            km_key       <= '0;
            km_algorithm <= '0;
            km_i         <= '0;
            rk.rk_valid  <= 1'b0;
            rk.rk_data   <= '0;
            rk.rk_round  <= '0;
            rk.rk_last   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (algorithm == 2'b11) begin
                            // Illegal algorithm: flag it, keep previous latches.
                            err <= 1'b1;
                        end else begin
                            km_key       <= key;
                            km_algorithm <= algorithm;
                            dir          <= decrypt;
                            km_i         <= decrypt ? last_round(algorithm) : {IDX_W{1'b0}};
                            busy         <= 1'b1;
                            state        <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        // Cancel before the key is captured; stream outputs hold.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // key_module has settled on km_i; capture its round key.
                        rk.rk_data  <= km_rk;
                        rk.rk_round <= km_i;
                        rk.rk_last  <= (km_i == end_index(dir, km_algorithm));
                        rk.rk_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        // Abort wins over a simultaneous handshake.
                        rk.rk_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (rk.rk_ready) begin
                        rk.rk_valid <= 1'b0;
                        if (rk.rk_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            // Not the last key, so the step cannot leave 0..Nr.
                            km_i  <= dir ? km_i - 1'b1 : km_i + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                default: begin
                    rk.rk_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Testbench for aes_round_key_sequencer. A behavioural AES key expansion
// stands in for key_module on the km_* bus and also produces the expected
// round keys pushed to the scoreboard when each schedule is started.
module tb_aes_round_key_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         decrypt = 1'b0;
    logic [255:0] key = '0;
    logic [1:0]   algorithm = 2'b00;
    logic [255:0] km_key;
    logic [1:0]   km_algorithm;
    logic [3:0]   km_i;
    logic [127:0] km_rk;
    logic         busy;
    logic         done;
    logic         err;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KALT = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   round;
        logic         last;
    } rk_t;

    rk_t exp_q[$];
    rk_t obs_q[$];

    int first_valid_cyc;
    int last_hs_cyc;
    int done_cyc;
    int stall_err;

    aes_round_key_sequencer_if #(.RK_W(128), .IDX_W(4)) rk_if ();

    aes_round_key_sequencer #(.KEY_W(256), .RK_W(128), .IDX_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .key          (key),
        .algorithm    (algorithm),
        .decrypt      (decrypt),
        .km_key       (km_key),
        .km_algorithm (km_algorithm),
        .km_i         (km_i),
        .km_rk        (km_rk),
        .rk           (rk_if),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // ---------------- AES key expansion reference ----------------
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        int idx;
        case (b[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        idx = 127 - 8 * int'(b[3:0]);
        return row[idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nr_of(input logic [1:0] alg);
        return (alg == 2'b00) ? 10 : (alg == 2'b01) ? 12 : 14;
    endfunction

    function automatic logic [127:0] model_rk(input logic [255:0] k, input logic [1:0] alg,
                                              input logic [3:0] r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int ri;
        if (alg == 2'b11) return '0;
        nk = (alg == 2'b00) ? 4 : (alg == 2'b01) ? 6 : 8;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < nk) begin
                w[i] = k[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xtime(rc);
                end else if (nk == 8 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        ri = int'(r);
        return {w[4*ri], w[4*ri+1], w[4*ri+2], w[4*ri+3]};
    endfunction

    // key_module stand-in: round key is combinational in km_*.
    assign km_rk = model_rk(km_key, km_algorithm, km_i);

    // ---------------- stimulus helpers ----------------
    task automatic push_schedule(input logic [255:0] k, input logic [1:0] alg, input logic dec);
        int nr;
        int r;
        rk_t e;
        nr = nr_of(alg);
        for (int j = 0; j <= nr; j++) begin
            r       = dec ? nr - j : j;
            e.data  = model_rk(k, alg, 4'(r));
            e.round = 4'(r);
            e.last  = (j == nr);
            exp_q.push_back(e);
        end
    endtask

    task automatic begin_schedule(input logic [255:0] k, input logic [1:0] alg, input logic dec);
        @(negedge clk);
        key       = k;
        algorithm = alg;
        decrypt   = dec;
        start     = 1'b1;
        push_schedule(k, alg, dec);
    endtask

    // Drives rk_ready and records every handshake until done (bounded).
    task automatic run_stream(input int ready_pct, input bit hold_start);
        bit  held_v;
        bit  rdy;
        rk_t held;
        rk_t cur;
        obs_q.delete();
        first_valid_cyc = -1;
        last_hs_cyc     = -1;
        done_cyc        = -1;
        stall_err       = 0;
        held_v          = 1'b0;
        held            = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (hold_start) begin
                key     = ~key;
                decrypt = ~decrypt;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                start    = 1'b0;
                break;
            end
            cur = {rk_if.rk_data, rk_if.rk_round, rk_if.rk_last};
            if (rk_if.rk_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rk_if.rk_valid && held_v && cur != held) stall_err++;
            rdy = ($urandom_range(0, 99) < ready_pct);
            rk_if.rk_ready = rdy;
            if (rk_if.rk_valid && rdy) begin
                obs_q.push_back(cur);
                last_hs_cyc = cyc;
                held_v      = 1'b0;
            end else if (rk_if.rk_valid) begin
                held_v = 1'b1;
                held   = cur;
            end
        end
        rk_if.rk_ready = 1'b0;
        start          = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (rk_if.rk_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rk_if.rk_valid); end
        total++; if (rk_if.rk_data !== 128'h0) begin bad++; $display("FAIL reset_data: got %h want 0", rk_if.rk_data); end
        total++; if ({rk_if.rk_round, rk_if.rk_last} !== 5'h0) begin bad++; $display("FAIL reset_round_last: got %h want 0", {rk_if.rk_round, rk_if.rk_last}); end
        total++; if ({km_key, km_algorithm, km_i} !== 262'h0) begin bad++; $display("FAIL reset_km: got %h want 0", {km_key, km_algorithm, km_i}); end
        total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
        rst_n = 1'b1;
    endtask

    task automatic test_aes128_enc();
        rk_t e, o, first, lastk;
        begin_schedule(K128, 2'b00, 1'b0);
        run_stream(100, 1'b0);
        first = (obs_q.size() > 0) ? obs_q[0] : '0;
        lastk = (obs_q.size() > 0) ? obs_q[$] : '0;
        total++; if (obs_q.size() != 11) begin bad++; $display("FAIL aes128_count: got %0d want 11", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL aes128_key r%0d: got %h/%0d/%b want %h/%0d/%b", e.round, o.data, o.round, o.last, e.data, e.round, e.last); end
        end
        exp_q.delete();
        total++; if (first.data !== 128'h000102030405060708090a0b0c0d0e0f || first.round !== 4'd0) begin bad++; $display("FAIL aes128_first: got %h r%0d", first.data, first.round); end
        total++; if (lastk !== {128'h13111d7fe3944a17f307a78b4d2b30c5, 4'd10, 1'b1}) begin bad++; $display("FAIL aes128_last: got %h r%0d l%b", lastk.data, lastk.round, lastk.last); end
        total++; if (first_valid_cyc != 1) begin bad++; $display("FAIL aes128_latency: got %0d want 1", first_valid_cyc); end
        total++; if (last_hs_cyc - first_valid_cyc != 20) begin bad++; $display("FAIL aes128_throughput: got %0d want 20", last_hs_cyc - first_valid_cyc); end
        total++; if (done_cyc != last_hs_cyc + 1) begin bad++; $display("FAIL aes128_done_timing: got %0d want %0d", done_cyc, last_hs_cyc + 1); end
        @(negedge clk);
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL aes128_done_pulse: got %b want 00", {done, busy}); end
    endtask

    task automatic test_aes192_dec();
        rk_t e, o, first, lastk;
        begin_schedule(K192, 2'b01, 1'b1);
        run_stream(100, 1'b0);
        first = (obs_q.size() > 0) ? obs_q[0] : '0;
        lastk = (obs_q.size() > 0) ? obs_q[$] : '0;
        total++; if (obs_q.size() != 13) begin bad++; $display("FAIL aes192_count: got %0d want 13", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL aes192_key r%0d: got %h/%0d/%b want %h/%0d/%b", e.round, o.data, o.round, o.last, e.data, e.round, e.last); end
        end
        exp_q.delete();
        total++; if (first !== {128'ha4970a331a78dc09c418c271e3a41d5d, 4'd12, 1'b0}) begin bad++; $display("FAIL aes192_first: got %h r%0d l%b", first.data, first.round, first.last); end
        total++; if (lastk !== {128'h000102030405060708090a0b0c0d0e0f, 4'd0, 1'b1}) begin bad++; $display("FAIL aes192_last: got %h r%0d l%b", lastk.data, lastk.round, lastk.last); end
        total++; if (done_cyc != last_hs_cyc + 1) begin bad++; $display("FAIL aes192_done_timing: got %0d want %0d", done_cyc, last_hs_cyc + 1); end
    endtask

    task automatic test_aes256_stall();
        rk_t e, o, lastk;
        begin_schedule(K256, 2'b10, 1'b0);
        run_stream(50, 1'b0);
        lastk = (obs_q.size() > 0) ? obs_q[$] : '0;
        total++; if (obs_q.size() != 15) begin bad++; $display("FAIL aes256_count: got %0d want 15", obs_q.size()); end
        total++; if (stall_err != 0) begin bad++; $display("FAIL aes256_stall_stable: got %0d changes want 0", stall_err); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL aes256_key r%0d: got %h/%0d/%b want %h/%0d/%b", e.round, o.data, o.round, o.last, e.data, e.round, e.last); end
        end
        exp_q.delete();
        total++; if (lastk !== {128'h24fc79ccbf0979e9371ac23c6d68de36, 4'd14, 1'b1}) begin bad++; $display("FAIL aes256_round14: got %h r%0d l%b", lastk.data, lastk.round, lastk.last); end
    endtask

    task automatic test_illegal_alg();
        bit seen;
        @(negedge clk);
        key       = KALT;
        algorithm = 2'b11;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if ({err, busy, rk_if.rk_valid} !== 3'b100) begin bad++; $display("FAIL illegal_err: got err/busy/valid=%b want 100", {err, busy, rk_if.rk_valid}); end
        total++; if (km_algorithm !== 2'b10 || km_key !== K256) begin bad++; $display("FAIL illegal_latch: got alg %b key %h", km_algorithm, km_key); end
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL illegal_err_pulse: got %b want 0", err); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rk_if.rk_valid || busy || err) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL illegal_quiet: got activity=%b want 0", seen); end
        algorithm = 2'b00;
    endtask

    task automatic test_abort();
        bit  found;
        bit  seen;
        rk_t e, o;
        @(negedge clk);
        key = K128; algorithm = 2'b00; decrypt = 1'b0; start = 1'b1;
        rk_if.rk_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (rk_if.rk_valid && rk_if.rk_round == 4'd5) begin
                found = 1'b1;
                abort = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL abort_reach_r5: got timeout want round 5"); end
        @(negedge clk);
        abort = 1'b0;
        rk_if.rk_ready = 1'b0;
        total++; if ({rk_if.rk_valid, busy, done} !== 3'b000) begin bad++; $display("FAIL abort_idle: got valid/busy/done=%b want 000", {rk_if.rk_valid, busy, done}); end
        total++; if (rk_if.rk_round !== 4'd5) begin bad++; $display("FAIL abort_hold_round: got %0d want 5", rk_if.rk_round); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || rk_if.rk_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got activity=%b want 0", seen); end
        begin_schedule(K128, 2'b00, 1'b0);
        run_stream(100, 1'b0);
        total++; if (obs_q.size() != 11) begin bad++; $display("FAIL abort_restart_count: got %0d want 11", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL abort_restart_key r%0d: got %h/%0d/%b want %h/%0d/%b", e.round, o.data, o.round, o.last, e.data, e.round, e.last); end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit found;
        bit seen;
        @(negedge clk);
        key = K256; algorithm = 2'b10; decrypt = 1'b0; start = 1'b1;
        rk_if.rk_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (rk_if.rk_valid) begin found = 1'b1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL rstmid_reach_issue: got timeout want rk_valid"); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({rk_if.rk_valid, rk_if.rk_data, rk_if.rk_round, rk_if.rk_last} !== 134'h0) begin bad++; $display("FAIL rstmid_stream: got v%b %h r%0d", rk_if.rk_valid, rk_if.rk_data, rk_if.rk_round); end
        total++; if ({km_key, km_algorithm, km_i, busy, done, err} !== 265'h0) begin bad++; $display("FAIL rstmid_ctrl: got alg %b i %0d flags %b", km_algorithm, km_i, {busy, done, err}); end
        @(negedge clk);
        rst_n = 1'b1;
        rk_if.rk_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || rk_if.rk_valid || busy) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_done: got activity=%b want 0", seen); end
        rk_if.rk_ready = 1'b0;
    endtask

    task automatic test_start_while_busy();
        rk_t e, o;
        begin_schedule(KALT, 2'b00, 1'b0);
        run_stream(100, 1'b1);
        total++; if (obs_q.size() != 11) begin bad++; $display("FAIL busy_start_count: got %0d want 11", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL busy_start_key r%0d: got %h/%0d/%b want %h/%0d/%b", e.round, o.data, o.round, o.last, e.data, e.round, e.last); end
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        total++; if ({busy, rk_if.rk_valid} !== 2'b00) begin bad++; $display("FAIL busy_start_idle: got busy/valid=%b want 00", {busy, rk_if.rk_valid}); end
    endtask

    initial begin
        rk_if.rk_ready = 1'b0;
        test_reset();
        test_aes128_enc();
        test_aes192_dec();
        test_aes256_stall();
        test_illegal_alg();
        test_abort();
        test_reset_mid();
        test_start_while_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
